// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32M op codes, mul/div FSM states and the
// small abs/negate helpers that the ALU also uses.
package otter_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, 32 radix-2 steps,
// sign fix-up in FINISH. Divide-by-zero and signed overflow bypass CALC.
module otter_muldiv
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] LAST = 5'(MULDIV_ITER - 1);

  muldiv_state_t state, next;
  muldiv_op_t    op;
  logic          is_div, neg, fast;
  logic [31:0]   b;       // multiplicand or divisor magnitude
  logic [31:0]   hi, lo;  // mul: product {hi,lo}; div: remainder hi, quotient lo
  logic [4:0]    cnt;

  // Operand conditioning for an incoming request
  logic        a_sgn, b_sgn, sgn, fp;
  logic [31:0] ua, ub, fp_val;

  always_comb begin
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    sgn    = 1'b0;
    fp     = 1'b0;
    fp_val = '0;
    case (muldiv_op_t'(funct3))
      OP_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; sgn = srcA[31] ^ srcB[31]; end
      OP_MULHSU: begin a_sgn = 1'b1; sgn = srcA[31]; end
      OP_DIV:    begin a_sgn = 1'b1; b_sgn = 1'b1; sgn = srcA[31] ^ srcB[31]; end
      OP_REM:    begin a_sgn = 1'b1; b_sgn = 1'b1; sgn = srcA[31]; end
      default:   ;
    endcase
    if (funct3[2]) begin
      if (srcB == 32'd0) begin
        fp     = 1'b1;
        fp_val = funct3[1] ? srcA : 32'hFFFF_FFFF;
      end else if (!funct3[0] && srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
        fp     = 1'b1;
        fp_val = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
    ua = a_sgn ? abs32(srcA) : srcA;
    ub = b_sgn ? abs32(srcB) : srcB;
  end

  // One radix-2 step of each algorithm
  logic [32:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
    div_shift = {hi, lo[31]};
    div_diff  = div_shift - {1'b0, b};
  end

  // Sign fix-up negates the full 64-bit product so MULH* borrow is correct
  logic [63:0] mul_full;
  logic [31:0] fin_val;

  always_comb begin
    mul_full = neg ? (64'd0 - {hi, lo}) : {hi, lo};
    fin_val  = '0;
    if (fast) fin_val = lo;
    else begin
      case (op)
        OP_MUL:                     fin_val = mul_full[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fin_val = mul_full[63:32];
        OP_DIV, OP_DIVU:            fin_val = neg ? neg32(lo) : lo;
        default:                    fin_val = neg ? neg32(hi) : hi;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = fp ? FINISH : CALC;
      CALC:    if (cnt == LAST) next = FINISH;
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      op     <= OP_MUL;
      is_div <= 1'b0;
      neg    <= 1'b0;
      fast   <= 1'b0;
      b      <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op     <= muldiv_op_t'(funct3);
          is_div <= funct3[2];
          neg    <= sgn;
          fast   <= fp;
          hi     <= '0;
          cnt    <= '0;
          if (fp) lo <= fp_val;
          else if (funct3[2]) begin b <= ub; lo <= ua; end
          else                begin b <= ua; lo <= ub; end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            if (!div_diff[32]) begin hi <= div_diff[31:0];  lo <= {lo[30:0], 1'b1}; end
            else               begin hi <= div_shift[31:0]; lo <= {lo[30:0], 1'b0}; end
          end else begin
            hi <= mul_sum[32:1];
            lo <= {mul_sum[0], lo[31:1]};
          end
        end
        FINISH: begin
          result <= fin_val;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_muldiv.sv
// Directed-vector bench for otter_muldiv: results, latency, busy window,
// handshake corner cases and mid-operation reset.
module tb_otter_muldiv;

  logic        CLK = 1'b0;
  logic        RST, start;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  otter_muldiv dut (
    .CLK(CLK), .RST(RST), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op (start for a single cycle), then check latency, busy window,
  // result, and that done is a single-cycle pulse.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] bb, input logic [31:0] exp, input int lat);
    int n, busy_n;
    @(negedge CLK);
    funct3 = f; srcA = a; srcB = bb; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0; busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busycyc"}, busy_n, lat);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk(tag, result, exp);
    @(posedge CLK); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, dn;
    RST = 1'b1; start = 1'b0; funct3 = 3'b000; srcA = '0; srcB = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge CLK); RST = 1'b0;

    do_op("mul_7x6",     3'b000, 32'd7,          32'd6,          32'h0000_002A, 33);
    do_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33);
    do_op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
    do_op("mulhsu_m1m1", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33);
    do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
    do_op("divu_m7_2",   3'b101, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, 33);
    do_op("divu_5_0",    3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    do_op("remu_5_0",    3'b111, 32'd5,          32'd0,          32'h0000_0005, 1);
    do_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
    do_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1);

    // Operands, funct3 and a second start changing while busy must be ignored
    @(negedge CLK);
    funct3 = 3'b000; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    funct3 = 3'b101; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    dn = 0;
    repeat (80) begin
      @(posedge CLK); #1;
      if (done) begin
        dn++;
        chk("stable_result", result, 32'd12);
      end
    end
    chk("stable_done_cnt", dn, 1);

    // start held through done: next op accepted at the edge ending the done cycle
    @(negedge CLK);
    funct3 = 3'b000; srcA = 32'd5; srcB = 32'd5; start = 1'b1;
    n = 0;
    @(posedge CLK); #1;
    while (!done && n < 100) begin @(posedge CLK); #1; n++; end
    chk("held_first_lat", n, 33);
    chk("held_first", result, 32'd25);
    srcA = 32'd6;
    @(posedge CLK); #1;
    chk("held_reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(posedge CLK); #1; n++; end
    chk("held_second_lat", n, 33);
    chk("held_second", result, 32'd30);

    // Reset mid-divide aborts with no done pulse
    @(negedge CLK);
    funct3 = 3'b100; srcA = 32'd100; srcB = 32'd3; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge CLK); RST = 1'b0;
    dn = 0;
    repeat (50) begin
      @(posedge CLK); #1;
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    do_op("mul_after_rst", 3'b000, 32'd2, 32'd2, 32'd4, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
